enemy_step_timer: RTL and testbench

Generates the one-cycle `mueva` step strobe that drives the enemy-formation movement logic (MovenLogic), directly upstream of it. Counts VGA frames via the vertical-sync input and fires `mueva` once every `period` frames. Shortens `period` as enemies are destroyed so the formation speeds up, and restores the period at the start of each wave.

---
 rtl/space_inv_pkg.sv | 32 +++
 rtl/enemy_step_timer_if.sv | 26 ++
 rtl/sync_edge_detect.sv | 29 ++
 rtl/enemy_step_timer.sv | 112 +++++++++++
 tb/tb_enemy_step_timer.sv | 284 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/space_inv_pkg.sv
// Shared Space Invaders definitions: control state, datapath widths and the
// default step timing also used by the movement logic and the HUD.
package space_inv_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  localparam int PERIOD_W           = 6;
  localparam int KILL_W             = 7;
  localparam int DEF_START_FRAMES   = 30;
  localparam int DEF_MIN_FRAMES     = 2;
  localparam int DEF_KILLS_PER_STEP = 4;
  localparam int DEF_STEP_DEC       = 2;

  // Shorten the period by dec without going below floor_v or wrapping below zero.
  function automatic logic [PERIOD_W-1:0] dec_period(
    input logic [KILL_W-1:0] cur,
    input logic [KILL_W-1:0] dec,
    input logic [KILL_W-1:0] floor_v
  );
    logic [KILL_W-1:0] diff;
    diff = cur - dec;
    if ((cur > dec) && (diff > floor_v)) begin
      dec_period = PERIOD_W'(diff);
    end else begin
      dec_period = PERIOD_W'(floor_v);
    end
  endfunction

endpackage

// File: rtl/enemy_step_timer_if.sv
// Control and status bundle between the game controller and enemy_step_timer.
interface enemy_step_timer_if;
  import space_inv_pkg::*;

  logic                vsync;
  logic                start;
  logic                stop;
  logic                pause;
  logic                kill;
  logic                wave_reset;
  logic                mueva;
  logic [PERIOD_W-1:0] period;
  logic [KILL_W-1:0]   kills;
  logic                running;

  modport master (
    output vsync, start, stop, pause, kill, wave_reset,
    input  mueva, period, kills, running
  );

  modport slave (
    input  vsync, start, stop, pause, kill, wave_reset,
    output mueva, period, kills, running
  );

endinterface

// File: rtl/sync_edge_detect.sv
// Brings an asynchronous level into the clk domain and emits a one-cycle
// pulse on each synchronized rising edge.
module sync_edge_detect (
  input  logic clk,
  input  logic rst_n,
  input  logic sig,
  output logic rise
);

  logic s1_r;
  logic s2_r;
  logic s3_r;

  // Two synchronizer stages followed by a delay stage for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_r <= 1'b0;
      s2_r <= 1'b0;
      s3_r <= 1'b0;
    end else begin
      s1_r <= sig;
      s2_r <= s1_r;
      s3_r <= s2_r;
    end
  end

  assign rise = s2_r & ~s3_r;

endmodule

// File: rtl/enemy_step_timer.sv
// Frame-based step strobe for the enemy formation; the step period shrinks
// as kills accumulate and is restored at each new wave.
module enemy_step_timer
  import space_inv_pkg::*;
#(
  parameter int START_FRAMES   = DEF_START_FRAMES,
  parameter int MIN_FRAMES     = DEF_MIN_FRAMES,
  parameter int KILLS_PER_STEP = DEF_KILLS_PER_STEP,
  parameter int STEP_DEC       = DEF_STEP_DEC
) (
  input  logic              clk,
  input  logic              reset,
  enemy_step_timer_if.slave bus
);

  localparam logic [PERIOD_W-1:0] START_P    = PERIOD_W'(START_FRAMES);
  localparam logic [KILL_W-1:0]   MIN_P      = KILL_W'(MIN_FRAMES);
  localparam logic [KILL_W-1:0]   DEC_P      = KILL_W'(STEP_DEC);
  localparam logic [KILL_W-1:0]   KILL_MAX   = {KILL_W{1'b1}};
  localparam logic [3:0]          GROUP_LAST = 4'(KILLS_PER_STEP - 1);

  state_e              state_r;
  logic [PERIOD_W-1:0] frame_cnt_r;
  logic [PERIOD_W-1:0] period_r;
  logic [KILL_W-1:0]   kills_r;
  logic [3:0]          group_cnt_r;
  logic                mueva_r;
  logic                frame_tick_s;
  logic                step_due_s;
  logic [PERIOD_W-1:0] period_dec_s;

  sync_edge_detect u_vsync_sync (
    .clk   (clk),
    .rst_n (reset),
    .sig   (bus.vsync),
    .rise  (frame_tick_s)
  );

  // >= rather than == so a period that shrank below the count still fires.
  assign step_due_s   = ({1'b0, frame_cnt_r} + 7'd1) >= {1'b0, period_r};
  assign period_dec_s = dec_period({1'b0, period_r}, DEC_P, MIN_P);

  // Control state, frame counting, kill accounting and the step strobe.
  // Later assignments in this block carry higher priority.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r     <= IDLE;
      frame_cnt_r <= '0;
      period_r    <= START_P;
      kills_r     <= '0;
      group_cnt_r <= 4'd0;
      mueva_r     <= 1'b0;
    end else begin
      mueva_r <= 1'b0;

      if (bus.kill) begin
        if (kills_r != KILL_MAX) begin
          kills_r <= kills_r + 7'd1;
        end
        if (group_cnt_r >= GROUP_LAST) begin
          group_cnt_r <= 4'd0;
          period_r    <= period_dec_s;
        end else begin
          group_cnt_r <= group_cnt_r + 4'd1;
        end
      end

      case (state_r)
        IDLE: begin
          frame_cnt_r <= '0;
          if (bus.start) begin
            state_r <= RUN;
          end
        end
        RUN: begin
          if (frame_tick_s && !bus.pause) begin
            if (step_due_s) begin
              frame_cnt_r <= '0;
              mueva_r     <= 1'b1;
            end else begin
              frame_cnt_r <= frame_cnt_r + 6'd1;
            end
          end
        end
        default: begin
          state_r     <= IDLE;
          frame_cnt_r <= '0;
        end
      endcase

      if (bus.wave_reset) begin
        period_r    <= START_P;
        kills_r     <= '0;
        group_cnt_r <= 4'd0;
        frame_cnt_r <= '0;
        mueva_r     <= 1'b0;
      end

      if (bus.stop) begin
        state_r     <= IDLE;
        frame_cnt_r <= '0;
        mueva_r     <= 1'b0;
      end
    end
  end

  assign bus.mueva   = mueva_r;
  assign bus.period  = period_r;
  assign bus.kills   = kills_r;
  assign bus.running = (state_r == RUN) && !bus.pause;

endmodule

// File: tb/tb_enemy_step_timer.sv
// Directed and randomized checks of enemy_step_timer against a frame/kill
// reference model evaluated once per clock.
module tb_enemy_step_timer;

  localparam int START = 30;
  localparam int MINF  = 2;
  localparam int KPS   = 4;
  localparam int DEC   = 2;

  logic clk   = 1'b0;
  logic reset = 1'b0;

  enemy_step_timer_if bus();

  enemy_step_timer #(
    .START_FRAMES   (START),
    .MIN_FRAMES     (MINF),
    .KILLS_PER_STEP (KPS),
    .STEP_DEC       (DEC)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_cmp      = 0;
  int n_bad      = 0;
  int mueva_seen = 0;

  // Reference model: game-level quantities, updated once per rising edge.
  bit m_run;
  bit m_mueva;
  int m_fc;
  int m_period;
  int m_kills;
  int m_grp;
  bit vs_hist [3];   // vsync seen at the last three edges, [0] most recent

  task automatic cmp(input string name, input int act, input int want);
    n_cmp++;
    if (act != want) begin
      n_bad++;
      $display("FAIL %s: actual %0d expected %0d", name, act, want);
    end
  endtask

  function automatic void model_reset();
    m_run = 1'b0; m_mueva = 1'b0; m_fc = 0;
    m_period = START; m_kills = 0; m_grp = 0;
    for (int i = 0; i < 3; i++) vs_hist[i] = 1'b0;
  endfunction

  function automatic void model_step();
    bit tick;
    bit old_run;
    int old_period;
    // A vsync rise seen two edges ago is acted on at this edge.
    tick = vs_hist[1] && !vs_hist[2];
    vs_hist[2] = vs_hist[1];
    vs_hist[1] = vs_hist[0];
    vs_hist[0] = bus.vsync;
    old_run    = m_run;
    old_period = m_period;
    m_mueva    = 1'b0;
    if (bus.kill) begin
      if (m_kills < 127) m_kills++;
      m_grp++;
      if (m_grp == KPS) begin
        m_grp = 0;
        m_period = (m_period - DEC < MINF) ? MINF : m_period - DEC;
      end
    end
    if (!old_run) begin
      m_fc = 0;
      if (bus.start) m_run = 1'b1;
    end else if (tick && !bus.pause) begin
      if (m_fc + 1 >= old_period) begin
        m_fc = 0;
        m_mueva = 1'b1;
      end else begin
        m_fc++;
      end
    end
    if (bus.wave_reset) begin
      m_period = START; m_kills = 0; m_grp = 0; m_fc = 0; m_mueva = 1'b0;
    end
    if (bus.stop) begin
      m_run = 1'b0; m_fc = 0; m_mueva = 1'b0;
    end
  endfunction

  task automatic check_outputs();
    cmp("mueva",   int'(bus.mueva),   int'(m_mueva));
    cmp("period",  int'(bus.period),  m_period);
    cmp("kills",   int'(bus.kills),   m_kills);
    cmp("running", int'(bus.running), int'(m_run && !bus.pause));
    if (bus.mueva) mueva_seen++;
  endtask

  // One clock: advance the model with the DUT, compare at the falling edge,
  // then drop the single-cycle pulse inputs.
  task automatic cyc();
    @(posedge clk);
    if (!reset) model_reset();
    else        model_step();
    @(negedge clk);
    check_outputs();
    bus.start = 1'b0; bus.stop = 1'b0; bus.kill = 1'b0; bus.wave_reset = 1'b0;
  endtask

  task automatic pulse(input bit kill_on_tick);
    bus.vsync = 1'b1;
    cyc(); cyc();
    bus.vsync = 1'b0;
    bus.kill  = kill_on_tick;
    cyc(); cyc(); cyc();
  endtask

  task automatic pulses(input int n);
    for (int i = 0; i < n; i++) pulse(1'b0);
  endtask

  task automatic kills_n(input int n);
    for (int i = 0; i < n; i++) begin
      bus.kill = 1'b1;
      cyc();
    end
  endtask

  initial begin
    bit found;
    bus.vsync = 1'b0; bus.start = 1'b0; bus.stop = 1'b0; bus.pause = 1'b0;
    bus.kill = 1'b0; bus.wave_reset = 1'b0;
    model_reset();
    repeat (3) cyc();
    cmp("rst_period",  int'(bus.period),  30);
    cmp("rst_kills",   int'(bus.kills),   0);
    cmp("rst_mueva",   int'(bus.mueva),   0);
    cmp("rst_running", int'(bus.running), 0);
    reset = 1'b1;
    cyc();

    // First step after start: exactly one strobe on the 30th frame.
    bus.start = 1'b1;
    cyc();
    cmp("start_running", int'(bus.running), 1);
    mueva_seen = 0;
    pulses(29);
    cmp("no_step_29", mueva_seen, 0);
    bus.vsync = 1'b1;
    cyc();
    cyc();
    cmp("lat_before", int'(bus.mueva), 0);
    bus.vsync = 1'b0;
    cyc();
    cmp("lat_k2", int'(bus.mueva), 1);
    cyc();
    cmp("width_1", int'(bus.mueva), 0);
    cyc();
    cmp("step_30", mueva_seen, 1);

    // Kill-driven speed-up, floor and wave restore.
    kills_n(4);
    cmp("p_4kills", int'(bus.period), 28);
    cmp("k_4kills", int'(bus.kills),  4);
    kills_n(32);
    cmp("p_36kills", int'(bus.period), 12);
    cmp("k_36kills", int'(bus.kills),  36);
    bus.wave_reset = 1'b1;
    cyc();
    cmp("wr_period",  int'(bus.period),  30);
    cmp("wr_kills",   int'(bus.kills),   0);
    cmp("wr_running", int'(bus.running), 1);
    kills_n(56);
    cmp("p_56kills", int'(bus.period), 2);
    cmp("k_56kills", int'(bus.kills),  56);
    kills_n(4);
    cmp("p_floor", int'(bus.period), 2);
    bus.wave_reset = 1'b1;
    cyc();

    // Pause holds the frame count; counting resumes from it.
    mueva_seen = 0;
    pulses(10);
    bus.pause = 1'b1;
    pulses(20);
    cmp("pause_no_step", mueva_seen, 0);
    cmp("pause_running", int'(bus.running), 0);
    bus.pause = 1'b0;
    pulses(19);
    cmp("resume_19", mueva_seen, 0);
    pulse(1'b0);
    cmp("resume_20", mueva_seen, 1);

    // Kill completing a group on a firing frame: old period decides the step.
    bus.wave_reset = 1'b1;
    cyc();
    kills_n(40);
    cmp("p_40kills", int'(bus.period), 10);
    kills_n(3);
    pulses(9);
    mueva_seen = 0;
    bus.vsync = 1'b1;
    cyc(); cyc();
    bus.vsync = 1'b0;
    bus.kill  = 1'b1;
    cyc();
    cmp("coinc_step",   int'(bus.mueva),  1);
    cmp("coinc_period", int'(bus.period), 8);
    cyc(); cyc();
    pulses(7);
    cmp("after_7", mueva_seen, 1);
    pulse(1'b0);
    cmp("after_8", mueva_seen, 2);

    // Kill count saturation.
    bus.wave_reset = 1'b1;
    cyc();
    kills_n(130);
    cmp("kills_sat", int'(bus.kills), 127);

    // stop wins over start.
    bus.stop = 1'b1; bus.start = 1'b1;
    cyc();
    cmp("stopstart_running", int'(bus.running), 0);
    cmp("stopstart_mueva",   int'(bus.mueva),   0);
    cyc();

    // Randomized traffic against the model.
    bus.wave_reset = 1'b1;
    cyc();
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 2) == 0) bus.vsync = ~bus.vsync;
      if ($urandom_range(0, 49) == 0) bus.pause = ~bus.pause;
      bus.start      = ($urandom_range(0, 19) == 0);
      bus.stop       = ($urandom_range(0, 149) == 0);
      bus.kill       = ($urandom_range(0, 5) == 0);
      bus.wave_reset = ($urandom_range(0, 199) == 0);
      if (bus.stop) bus.kill = 1'b0;
      if (bus.wave_reset) begin
        bus.kill  = 1'b0;
        bus.start = 1'b0;
      end
      cyc();
    end
    bus.pause = 1'b0;
    bus.vsync = 1'b0;

    // Asynchronous reset while a step strobe is high.
    bus.stop = 1'b1; bus.wave_reset = 1'b1;
    cyc();
    bus.start = 1'b1;
    cyc();
    kills_n(5);
    found = 1'b0;
    for (int i = 0; i < 400; i++) begin
      bus.vsync = ((i % 5) < 2);
      cyc();
      if (m_mueva) begin
        found = 1'b1;
        break;
      end
    end
    cmp("pending_found", int'(found), 1);
    cmp("pending_mueva", int'(bus.mueva), 1);
    #1 reset = 1'b0;
    #1;
    cmp("arst_mueva",   int'(bus.mueva),   0);
    cmp("arst_period",  int'(bus.period),  30);
    cmp("arst_kills",   int'(bus.kills),   0);
    cmp("arst_running", int'(bus.running), 0);
    model_reset();
    bus.vsync = 1'b0;
    repeat (2) cyc();
    reset = 1'b1;
    repeat (4) cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
